// File: rtl/i2c_slave_block.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_slave_block
//  Purpose  : 7-bit address I2C slave transfer engine. Synchronises the bus,
//             detects START/STOP, ACKs a matching address, receives write
//             bytes and serialises read bytes supplied by the host logic.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i2c_core_clock_i  core clock, rising edge
//    reset_bit_i       asynchronous reset, active-high
//    scl_i / sda_i     asynchronous bus inputs
//    own_addr_i        7-bit slave address (change only while busy_o=0)
//    data_i            next read byte, sampled one cycle after tx_req_o
//    ack_en_i          1 = ACK received write bytes, 0 = NACK them
//    sda_o             open-drain SDA control (0 = pull low, 1 = release)
//    data_o            last received write byte
//    data_valid_o      one-cycle pulse, data_o updated in the same cycle
//    rw_o              R/W bit of the last matched address (1 = read)
//    tx_req_o          one-cycle request for the next read byte
//    nack_o            one-cycle pulse when the master NACKs a read byte
//    busy_o            addressed from matching START until STOP/mismatch
// ============================================================================
module i2c_slave_block #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i2c_core_clock_i,
  input  logic       reset_bit_i,
  input  logic       scl_i,
  input  logic       sda_i,
  input  logic [6:0] own_addr_i,
  input  logic [7:0] data_i,
  input  logic       ack_en_i,
  output logic       sda_o,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       rw_o,
  output logic       tx_req_o,
  output logic       nack_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WR_DATA   = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_RD_DATA   = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  // Synchroniser chains; the last stage is the usable bus value.
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;

  logic scl_s;
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  state_t     state_q;
  logic [2:0] cnt_q;
  logic       full_q;      // eight bits of the current byte have been clocked
  logic [7:0] shift_q;
  logic       tx_load_q;   // delayed tx_req: load data_i this cycle
  logic       sda_q;
  logic [7:0] data_q;
  logic       data_valid_q;
  logic       rw_q;
  logic       tx_req_q;
  logic       nack_q;
  logic       busy_q;

  always_ff @(posedge i2c_core_clock_i or posedge reset_bit_i) begin
    if (reset_bit_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // START/STOP only count when SCL is high and steady across the SDA edge.
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  always_ff @(posedge i2c_core_clock_i or posedge reset_bit_i) begin
    if (reset_bit_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      full_q       <= 1'b0;
      shift_q      <= 8'h00;
      tx_load_q    <= 1'b0;
      sda_q        <= 1'b1;
      data_q       <= 8'h00;
      data_valid_q <= 1'b0;
      rw_q         <= 1'b0;
      tx_req_q     <= 1'b0;
      nack_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      tx_req_q     <= 1'b0;
      nack_q       <= 1'b0;
      tx_load_q    <= tx_req_q;
      // The host presents the read byte in the cycle after tx_req_o.
      if (tx_load_q) shift_q <= data_i;

      if (start_det) begin
        state_q <= ST_ADDR;
        cnt_q   <= 3'd0;
        full_q  <= 1'b0;
        sda_q   <= 1'b1;
      end else if (stop_det) begin
        state_q <= ST_IDLE;
        sda_q   <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        if (scl_rise && (state_q == ST_ADDR || state_q == ST_WR_DATA ||
                         state_q == ST_RD_DATA)) begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) full_q <= 1'b1;
        end

        case (state_q)
          ST_ADDR: begin
            if (scl_rise) begin
              shift_q <= {shift_q[6:0], sda_s};
            end else if (scl_fall && full_q) begin
              full_q <= 1'b0;
              cnt_q  <= 3'd0;
              if (shift_q[7:1] == own_addr_i) begin
                rw_q     <= shift_q[0];
                busy_q   <= 1'b1;
                sda_q    <= 1'b0;
                tx_req_q <= shift_q[0];
                state_q  <= ST_ADDR_ACK;
              end else begin
                busy_q  <= 1'b0;
                state_q <= ST_WAIT_STOP;
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              cnt_q  <= 3'd0;
              full_q <= 1'b0;
              if (rw_q) begin
                sda_q   <= shift_q[7];
                shift_q <= {shift_q[6:0], 1'b1};
                state_q <= ST_RD_DATA;
              end else begin
                sda_q   <= 1'b1;
                state_q <= ST_WR_DATA;
              end
            end
          end

          ST_WR_DATA: begin
            if (scl_rise) begin
              shift_q <= {shift_q[6:0], sda_s};
            end else if (scl_fall && full_q) begin
              full_q       <= 1'b0;
              cnt_q        <= 3'd0;
              data_q       <= shift_q;
              data_valid_q <= 1'b1;
              sda_q        <= ~ack_en_i;
              state_q      <= ST_WR_ACK;
            end
          end

          ST_WR_ACK: begin
            if (scl_fall) begin
              sda_q   <= 1'b1;
              cnt_q   <= 3'd0;
              full_q  <= 1'b0;
              state_q <= ST_WR_DATA;
            end
          end

          ST_RD_DATA: begin
            if (scl_fall) begin
              if (full_q) begin
                full_q  <= 1'b0;
                cnt_q   <= 3'd0;
                sda_q   <= 1'b1;
                state_q <= ST_RD_ACK;
              end else begin
                sda_q   <= shift_q[7];
                shift_q <= {shift_q[6:0], 1'b1};
              end
            end
          end

          ST_RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                tx_req_q <= 1'b1;
              end else begin
                nack_q  <= 1'b1;
                sda_q   <= 1'b1;
                state_q <= ST_WAIT_STOP;
              end
            end else if (scl_fall) begin
              // Only reachable after an ACK; the NACK path has already left.
              cnt_q   <= 3'd0;
              full_q  <= 1'b0;
              sda_q   <= shift_q[7];
              shift_q <= {shift_q[6:0], 1'b1};
              state_q <= ST_RD_DATA;
            end
          end

          ST_IDLE, ST_WAIT_STOP: begin
            sda_q <= 1'b1;
          end

          default: begin
            sda_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign sda_o        = sda_q;
  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;
  assign rw_o         = rw_q;
  assign tx_req_o     = tx_req_q;
  assign nack_o       = nack_q;
  assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_block.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_slave_block
//  Purpose  : Directed bus-master bench for i2c_slave_block (write, read,
//             address mismatch, repeated START, NACKed write, mid-read reset).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_block;

  localparam int Q = 8;  // quarter SCL period in core clocks

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [6:0] own_addr = 7'h3A;
  logic [7:0] data_in = 8'h00;
  logic       ack_en = 1'b1;
  logic       sda_o;
  logic [7:0] data_o;
  logic       data_valid;
  logic       rw;
  logic       tx_req;
  logic       nack;
  logic       busy;
  logic       sda_bus;

  int checks = 0;
  int errors = 0;

  // Pulse monitor
  int   dv_cnt = 0, tx_cnt = 0, nack_cnt = 0, low_cnt = 0, width_err = 0;
  logic dv_p = 1'b0, tx_p = 1'b0, nk_p = 1'b0;

  assign sda_bus = sda_m & sda_o;

  always #5 clk = ~clk;

  i2c_slave_block #(.SYNC_STAGES(2)) dut (
    .i2c_core_clock_i (clk),
    .reset_bit_i      (rst),
    .scl_i            (scl_m),
    .sda_i            (sda_bus),
    .own_addr_i       (own_addr),
    .data_i           (data_in),
    .ack_en_i         (ack_en),
    .sda_o            (sda_o),
    .data_o           (data_o),
    .data_valid_o     (data_valid),
    .rw_o             (rw),
    .tx_req_o         (tx_req),
    .nack_o           (nack),
    .busy_o           (busy)
  );

  always @(negedge clk) begin
    if (data_valid && !dv_p) dv_cnt++;
    if (tx_req && !tx_p) tx_cnt++;
    if (nack && !nk_p) nack_cnt++;
    if ((data_valid && dv_p) || (tx_req && tx_p) || (nack && nk_p)) width_err++;
    if (!sda_o) low_cnt++;
    dv_p = data_valid;
    tx_p = tx_req;
    nk_p = nack;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q;
    repeat (Q) @(negedge clk);
  endtask

  task automatic m_start;
    sda_m = 1'b1; wait_q;
    scl_m = 1'b1; wait_q;
    sda_m = 1'b0; wait_q;
    scl_m = 1'b0; wait_q;
  endtask

  task automatic m_stop;
    sda_m = 1'b0; wait_q;
    scl_m = 1'b1; wait_q;
    sda_m = 1'b1; wait_q;
  endtask

  // One SCL period; s is the bus value sampled mid-high.
  task automatic m_bit(input logic b, output logic s);
    sda_m = b;    wait_q;
    scl_m = 1'b1; wait_q;
    s = sda_bus;  wait_q;
    scl_m = 1'b0; wait_q;
  endtask

  task automatic m_write(input logic [7:0] v, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(v[i], s);
    m_bit(1'b1, ack);
  endtask

  task automatic m_read8(output logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, s);
      v[i] = s;
    end
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] rd;
    int dv0, tx0, nk0, lo0;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_sda", sda_o, 1);
    check("rst_busy", busy, 0);
    check("rst_data", data_o, 8'h00);
    check("rst_rw", rw, 0);
    check("rst_pulses", {data_valid, tx_req, nack}, 3'b000);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Write 0x74 then 0xC5, STOP
    dv0 = dv_cnt;
    m_start;
    m_write(8'h74, ack);
    check("wr_addr_ack", ack, 0);
    check("wr_rw", rw, 0);
    m_write(8'hC5, ack);
    check("wr_data_ack", ack, 0);
    check("wr_data", data_o, 8'hC5);
    check("wr_dv_count", dv_cnt - dv0, 1);
    check("wr_busy", busy, 1);
    m_stop;
    check("wr_busy_stop", busy, 0);

    // Read 0x75: 0xA6 (ACK), 0x5B (NACK)
    tx0 = tx_cnt; nk0 = nack_cnt;
    data_in = 8'hA6;
    m_start;
    m_write(8'h75, ack);
    check("rd_addr_ack", ack, 0);
    check("rd_rw", rw, 1);
    m_read8(rd);
    check("rd_byte1", rd, 8'hA6);
    data_in = 8'h5B;
    m_bit(1'b0, s);
    m_read8(rd);
    check("rd_byte2", rd, 8'h5B);
    m_bit(1'b1, s);
    check("rd_tx_count", tx_cnt - tx0, 2);
    check("rd_nack_count", nack_cnt - nk0, 1);
    check("rd_sda_released", sda_o, 1);
    m_stop;
    check("rd_busy_stop", busy, 0);

    // Address mismatch 0x12
    dv0 = dv_cnt; tx0 = tx_cnt; nk0 = nack_cnt; lo0 = low_cnt;
    m_start;
    m_write(8'h12, ack);
    check("mm_ack", ack, 1);
    m_write(8'hFF, ack);
    check("mm_busy", busy, 0);
    check("mm_sda_low_cycles", low_cnt - lo0, 0);
    check("mm_pulses", (dv_cnt - dv0) + (tx_cnt - tx0) + (nack_cnt - nk0), 0);
    m_start;
    m_write(8'h74, ack);
    check("mm_next_ack", ack, 0);
    m_stop;

    // Repeated START: write 0x74 then read 0x75
    tx0 = tx_cnt;
    data_in = 8'h81;
    m_start;
    m_write(8'h74, ack);
    check("rs_wr_ack", ack, 0);
    check("rs_rw0", rw, 0);
    m_start;
    m_write(8'h75, ack);
    check("rs_rd_ack", ack, 0);
    check("rs_rw1", rw, 1);
    check("rs_tx_count", tx_cnt - tx0, 1);
    check("rs_busy", busy, 1);
    m_read8(rd);
    check("rs_byte", rd, 8'h81);
    m_bit(1'b1, s);
    m_stop;

    // Write with ack_en=0
    dv0 = dv_cnt;
    ack_en = 1'b0;
    m_start;
    m_write(8'h74, ack);
    check("na_addr_ack", ack, 0);
    m_write(8'h3C, ack);
    check("na_data_ack", ack, 1);
    check("na_dv_count", dv_cnt - dv0, 1);
    check("na_data", data_o, 8'h3C);
    m_stop;
    ack_en = 1'b1;

    // Reset mid-read while slave drives 0
    data_in = 8'h00;
    m_start;
    m_write(8'h75, ack);
    check("mr_addr_ack", ack, 0);
    check("mr_sda_low", sda_o, 0);
    rst = 1'b1;
    #1;
    check("mr_sda_async", sda_o, 1);
    check("mr_busy_async", busy, 0);
    check("mr_rw_async", rw, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    m_start;
    m_write(8'h74, ack);
    check("mr_restart_ack", ack, 0);
    check("mr_restart_busy", busy, 1);
    m_stop;
    check("mr_stop_busy", busy, 0);

    check("pulse_width", width_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_slave_block.md
I2C_SLAVE_BLOCK -- requirements
Module: i2c_slave_block

Interface
Parameters (name, default, meaning):
REQ-001 SYNC_STAGES, 2, number of synchronizer flops on scl_i and sda_i; minimum 2.
Ports (name direction width meaning):
REQ-002 i2c_core_clock_i  input  1  core clock; all logic is on its rising edge.
REQ-003 reset_bit_i  input  1  asynchronous reset, active-high.
REQ-004 scl_i  input  1  bus SCL, asynchronous.
REQ-005 sda_i  input  1  bus SDA, asynchronous.
REQ-006 own_addr_i  input  7  slave address; quasi-static, changed only while busy_o=0.
REQ-007 data_i  input  8  read-transfer byte; sampled one cycle after tx_req_o.
REQ-008 ack_en_i  input  1  1 = ACK received write data bytes, 0 = NACK them.
REQ-009 sda_o  output  1  open-drain SDA control; 0 = pull low, 1 = release.
REQ-010 data_o  output  8  last received write data byte.
REQ-011 data_valid_o  output  1  one-cycle pulse; data_o is updated in the same cycle.
REQ-012 rw_o  output  1  R/W bit of the last matched address; 1 = read.
REQ-013 tx_req_o  output  1  one-cycle pulse requesting the next read byte on data_i.
REQ-014 nack_o  output  1  one-cycle pulse when the master NACKs a read byte.
REQ-015 busy_o  output  1  high from a START with an address match until STOP, or until a START for another address.

Function
REQ-016 The block SHALL synchronize scl_i and sda_i through SYNC_STAGES flops.
REQ-017 Edges are detected on the synchronized signals using a one-cycle history.
- scl_rise / scl_fall: SCL 0->1 / 1->0.
- START: SDA 1->0 while SCL=1 and SCL unchanged.
- STOP: SDA 0->1 under the same condition.
REQ-018 The FSM states SHALL be IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-019 START in any state SHALL clear the 3-bit bit counter, release SDA and enter ADDR; this is also the repeated-START path.
REQ-020 STOP in any state SHALL release SDA and enter IDLE.
REQ-021 Received bits SHALL be sampled on scl_rise, MSB first.
- The bit counter increments on each sampled bit.
- After 8 bits, the state advances on the next scl_fall.
REQ-022 ADDR, address match (byte[7:1]==own_addr_i):
- Latch rw_o = byte[0].
- Set busy_o.
- Drive sda_o=0 one cycle after that scl_fall.
- Enter ADDR_ACK.
REQ-023 ADDR, mismatch: sda_o stays 1; enter WAIT_STOP (left only by START or STOP).
REQ-024 ADDR_ACK:
- On rw_o=1, pulse tx_req_o in the cycle ADDR_ACK is entered.
- At the scl_fall ending the ACK bit, go to RD_DATA (rw_o=1) or WR_DATA (rw_o=0).
- For WR_DATA, release sda_o one cycle after that fall.
REQ-025 WR_DATA, eighth bit complete (at scl_fall):
- Load data_o and pulse data_valid_o in the same cycle.
- One cycle later, drive sda_o = ~ack_en_i (ack_en_i sampled at that fall).
- Enter WR_ACK.
REQ-026 WR_ACK, next scl_fall: release sda_o one cycle later; return to WR_DATA with counter 0.
REQ-027 RD_DATA:
- Load the shift register from data_i one cycle after tx_req_o.
- Drive bit 7 one cycle after the scl_fall that ended the preceding ACK.
- Drive each following bit one cycle after each scl_fall.
- After 8 bits, release sda_o at the next scl_fall + 1 cycle and enter RD_ACK.
REQ-028 RD_ACK:
- Sample SDA on scl_rise.
- 0 (ACK): pulse tx_req_o immediately; enter RD_DATA at the next scl_fall.
- 1 (NACK): pulse nack_o; enter WAIT_STOP with sda_o=1.
REQ-029 Output pulses SHALL never exceed one cycle.
REQ-030 In ADDR, WR_DATA and RD_ACK, sda_o SHALL be 1.
REQ-031 The block SHALL never stretch SCL.

Reset
REQ-032 While reset_bit_i=1:
- state=IDLE, bit counter=0, synchronizers=1, sda_o=1.
- data_o=0, data_valid_o=0, rw_o=0, tx_req_o=0, nack_o=0, busy_o=0.
- These values apply immediately and asynchronously, including mid-transfer.
REQ-033 After reset deassertion, the block SHALL ignore the bus until the next START, even if one is in progress.

Verification
REQ-034 own_addr_i=7'h3A; master writes address 8'h74, then data 8'hC5, ack_en_i=1, then STOP:
- ACK low during both ACK bits.
- data_o=8'hC5 with a single data_valid_o pulse.
- busy_o falls at STOP.
REQ-035 own_addr_i=7'h3A; master reads with address 8'h75; data_i=8'hA6 then 8'h5B; master ACKs byte 1 and NACKs byte 2:
- sda_o serializes 10100110 then 01011011.
- Two tx_req_o pulses, one nack_o pulse, then WAIT_STOP.
REQ-036 Address 8'h12 with own_addr_i=7'h3A:
- sda_o=1 throughout.
- busy_o=0, no pulses.
- Next START with 8'h74 is ACKed.
REQ-037 Write 8'h74 then repeated START with 8'h75:
- rw_o goes 0 -> 1.
- tx_req_o pulses.
- No STOP is required in between.
REQ-038 Write with ack_en_i=0 → sda_o=1 during the data ACK bit; data_valid_o still pulses.
REQ-039 reset_bit_i=1 asserted mid-RD_DATA while sda_o=0 → sda_o=1 in the same cycle; the next transfer starts cleanly after a new START.
